// File: rtl/pcie_dllp_crc_engine.sv
// DLLP CRC-16 engine (poly 0x100B, LSB-first): accumulates byte-enabled beats
// of a frame and presents the final CRC and receive-side compare on a held result port.
module pcie_dllp_crc_engine #(
  parameter int          DATA_W     = 32,
  parameter logic [15:0] POLY_REFL  = 16'hD008,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter bit          OUT_INVERT = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_W-1:0]     s_data_i,
  input  logic [DATA_W/8-1:0]   s_keep_i,
  input  logic                  s_last_i,
  input  logic                  s_clear_i,
  input  logic [15:0]           crc_rx_i,
  output logic                  crc_valid_o,
  input  logic                  crc_ready_i,
  output logic [15:0]           crc_o,
  output logic                  crc_match_o
);

  localparam int LANES = DATA_W / 8;
  localparam logic [LANES-1:0] KEEP_ONE = (LANES)'(1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] crc_q, crc_d;
  logic        valid_q, valid_d;
  logic        match_q, match_d;
  logic [15:0] beat_crc;
  logic [15:0] final_crc;
  logic        keep_contig;

  function automatic logic [15:0] byte_step(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Lane 0 is folded first; byte enables only mask lanes on the last beat.
  always_comb begin
    beat_crc = acc_q;
    for (int l = 0; l < LANES; l++) begin
      if (!s_last_i || s_keep_i[l]) begin
        beat_crc = byte_step(beat_crc, s_data_i[8*l +: 8]);
      end
    end
  end

  assign final_crc = OUT_INVERT ? ~beat_crc : beat_crc;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    crc_d     = crc_q;
    valid_d   = valid_q;
    match_d   = match_q;
    s_ready_o = 1'b0;
    case (state_q)
      ACCUM: begin
        s_ready_o = 1'b1;
        // A clear wins over any beat in the same cycle, which is accepted and dropped.
        if (s_clear_i) begin
          acc_d = CRC_INIT;
        end else if (s_valid_i) begin
          if (s_last_i) begin
            crc_d   = final_crc;
            match_d = (final_crc == crc_rx_i);
            valid_d = 1'b1;
            acc_d   = CRC_INIT;
            state_d = DONE;
          end else begin
            acc_d = beat_crc;
          end
        end
      end
      DONE: begin
        if (crc_ready_i) begin
          valid_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
    if (rst_i) begin
      s_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      acc_q   <= CRC_INIT;
      crc_q   <= 16'h0000;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      match_q <= match_d;
    end
  end

  assign crc_o       = crc_q;
  assign crc_valid_o = valid_q;
  assign crc_match_o = match_q;

  // Enables on a last beat must form a run of ones starting at lane 0.
  assign keep_contig = ((s_keep_i & (s_keep_i + KEEP_ONE)) == '0);

  keep_contiguous_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (s_valid_i && s_ready_o && s_last_i && !s_clear_i) |-> keep_contig);

endmodule

// File: tb/tb_pcie_dllp_crc_engine.sv
// Bench for pcie_dllp_crc_engine: three widths share stimulus buses and are
// checked against a byte-serial CRC model with directed and random frames.
module tb_pcie_dllp_crc_engine;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic        s_last;
  logic        s_clear;
  logic        crc_ready;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic [15:0] crc_rx;
  logic        v8, v16, v32;
  logic        r8, r16, r32;
  logic        cv8, cv16, cv32;
  logic        m8, m16, m32;
  logic [15:0] c8, c16, c32;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pcie_dllp_crc_engine #(.DATA_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v8), .s_ready_o(r8),
    .s_data_i(s_data[7:0]), .s_keep_i(s_keep[0:0]), .s_last_i(s_last),
    .s_clear_i(s_clear), .crc_rx_i(crc_rx), .crc_valid_o(cv8),
    .crc_ready_i(crc_ready), .crc_o(c8), .crc_match_o(m8)
  );

  pcie_dllp_crc_engine #(.DATA_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v16), .s_ready_o(r16),
    .s_data_i(s_data[15:0]), .s_keep_i(s_keep[1:0]), .s_last_i(s_last),
    .s_clear_i(s_clear), .crc_rx_i(crc_rx), .crc_valid_o(cv16),
    .crc_ready_i(crc_ready), .crc_o(c16), .crc_match_o(m16)
  );

  pcie_dllp_crc_engine #(.DATA_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v32), .s_ready_o(r32),
    .s_data_i(s_data[31:0]), .s_keep_i(s_keep[3:0]), .s_last_i(s_last),
    .s_clear_i(s_clear), .crc_rx_i(crc_rx), .crc_valid_o(cv32),
    .crc_ready_i(crc_ready), .crc_o(c32), .crc_match_o(m32)
  );

  // Reference: CRC of the whole byte stream, one byte at a time, then complemented.
  function automatic logic [15:0] crcModel(input byte_q_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'hD008) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic getReady(input int w);
    case (w)
      8:       return r8;
      16:      return r16;
      default: return r32;
    endcase
  endfunction

  function automatic logic getValid(input int w);
    case (w)
      8:       return cv8;
      16:      return cv16;
      default: return cv32;
    endcase
  endfunction

  function automatic logic [15:0] getCrc(input int w);
    case (w)
      8:       return c8;
      16:      return c16;
      default: return c32;
    endcase
  endfunction

  function automatic logic getMatch(input int w);
    case (w)
      8:       return m8;
      16:      return m16;
      default: return m32;
    endcase
  endfunction

  task automatic setValid(input int w, input logic v);
    v8  = (w == 8)  ? v : 1'b0;
    v16 = (w == 16) ? v : 1'b0;
    v32 = (w == 32) ? v : 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends a whole frame on one engine; leaves it idle again if crc_ready is high.
  task automatic applyStimulus(input int w, input byte_q_t bytes, input logic [15:0] rx,
                               output logic [15:0] crc, output logic match);
    int bpb, n, nb, cnt, idx;
    bpb = w / 8;
    n = bytes.size();
    nb = (n == 0) ? 1 : (n + bpb - 1) / bpb;
    crc_rx = rx;
    s_clear = 1'b0;
    for (int b = 0; b < nb; b++) begin
      s_data = '0;
      s_keep = '0;
      for (int l = 0; l < bpb; l++) begin
        idx = b * bpb + l;
        if (idx < n) begin
          s_data[8*l +: 8] = bytes[idx];
          s_keep[l] = 1'b1;
        end
      end
      s_last = (b == nb - 1);
      setValid(w, 1'b1);
      cnt = 0;
      while (getReady(w) !== 1'b1 && cnt < 20) begin
        step;
        cnt++;
      end
      if (cnt == 20) checkOutput($sformatf("w%0d_ready_timeout", w), 16'(getReady(w)), 16'd1);
      step;
    end
    setValid(w, 1'b0);
    s_last = 1'b0;
    checkOutput($sformatf("w%0d_latency_valid", w), 16'(getValid(w)), 16'd1);
    crc = getCrc(w);
    match = getMatch(w);
    if (crc_ready) begin
      step;
      checkOutput($sformatf("w%0d_valid_drop", w), 16'(getValid(w)), 16'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t     q;
    logic [15:0] crc, expv, saved;
    logic        match;
    int          widths [3] = '{8, 16, 32};
    int          len;

    rst = 1'b1; s_last = 1'b0; s_clear = 1'b0; crc_ready = 1'b1;
    s_data = '0; s_keep = '0; crc_rx = '0; v8 = 1'b0; v16 = 1'b0; v32 = 1'b0;
    step;
    step;
    checkOutput("rst_ready", 16'(r32), 16'd0);
    checkOutput("rst_valid", 16'(cv32), 16'd0);
    checkOutput("rst_crc", c32, 16'h0000);
    checkOutput("rst_match", 16'(m32), 16'd0);
    rst = 1'b0;
    step;
    checkOutput("ready_after_rst", 16'(r32), 16'd1);

    $display("[TB] single zero byte at DATA_W=8");
    q = {8'h00};
    applyStimulus(8, q, 16'hF660, crc, match);
    checkOutput("w8_zero_crc", crc, 16'hF660);
    checkOutput("w8_zero_match", 16'(match), 16'd1);

    $display("[TB] empty last beat at DATA_W=32");
    q = {};
    applyStimulus(32, q, 16'h0001, crc, match);
    checkOutput("w32_empty_crc", crc, 16'h0000);
    checkOutput("w32_empty_match", 16'(match), 16'd0);

    $display("[TB] random 4-byte payloads on all widths");
    for (int it = 0; it < 4; it++) begin
      q = {};
      for (int k = 0; k < 4; k++) q.push_back(8'($urandom));
      expv = crcModel(q);
      foreach (widths[wi]) begin
        applyStimulus(widths[wi], q, (it % 2 == 1) ? (expv ^ 16'h0001) : expv, crc, match);
        checkOutput($sformatf("w%0d_rand4_crc", widths[wi]), crc, expv);
        checkOutput($sformatf("w%0d_rand4_match", widths[wi]), 16'(match), 16'(it % 2 == 0));
      end
    end

    $display("[TB] 6-byte frame at DATA_W=32");
    q = {};
    for (int k = 0; k < 6; k++) q.push_back(8'($urandom));
    applyStimulus(32, q, 16'h0000, crc, match);
    checkOutput("w32_six_crc", crc, crcModel(q));

    $display("[TB] random-length frames on all widths");
    for (int it = 0; it < 3; it++) begin
      len = $urandom_range(1, 11);
      q = {};
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      expv = crcModel(q);
      foreach (widths[wi]) begin
        applyStimulus(widths[wi], q, expv, crc, match);
        checkOutput($sformatf("w%0d_randlen_crc", widths[wi]), crc, expv);
        checkOutput($sformatf("w%0d_randlen_match", widths[wi]), 16'(match), 16'd1);
      end
    end

    $display("[TB] result backpressure");
    crc_ready = 1'b0;
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(8'($urandom));
    applyStimulus(32, q, 16'h0000, crc, match);
    checkOutput("bp_crc", crc, crcModel(q));
    saved = crc;
    s_data = 64'($urandom);
    s_keep = 8'h0F;
    s_last = 1'b1;
    s_clear = 1'b1;
    v32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      checkOutput("bp_valid_held", 16'(cv32), 16'd1);
      checkOutput("bp_crc_stable", c32, saved);
      checkOutput("bp_not_ready", 16'(r32), 16'd0);
    end
    v32 = 1'b0;
    s_last = 1'b0;
    s_clear = 1'b0;
    crc_ready = 1'b1;
    step;
    checkOutput("bp_release_valid", 16'(cv32), 16'd0);
    checkOutput("bp_release_ready", 16'(r32), 16'd1);
    q = {8'h00};
    applyStimulus(32, q, 16'hF660, crc, match);
    checkOutput("bp_after_crc", crc, 16'hF660);

    $display("[TB] clear mid-frame");
    s_data = 64'($urandom);
    s_keep = 8'h0F;
    s_last = 1'b0;
    v32 = 1'b1;
    step;
    s_clear = 1'b1;
    s_data = 64'($urandom);
    step;
    s_last = 1'b1;
    step;
    checkOutput("clr_no_result", 16'(cv32), 16'd0);
    s_clear = 1'b0;
    s_last = 1'b0;
    v32 = 1'b0;
    step;
    checkOutput("clr_no_result_later", 16'(cv32), 16'd0);
    q = {8'h00};
    applyStimulus(32, q, 16'hF660, crc, match);
    checkOutput("clr_fresh_crc", crc, 16'hF660);
    checkOutput("clr_fresh_match", 16'(match), 16'd1);

    $display("[TB] reset mid-frame and during result hold");
    s_data = 64'($urandom);
    s_keep = 8'h0F;
    s_last = 1'b0;
    v32 = 1'b1;
    step;
    v32 = 1'b0;
    rst = 1'b1;
    step;
    checkOutput("rstmid_valid", 16'(cv32), 16'd0);
    checkOutput("rstmid_ready", 16'(r32), 16'd0);
    rst = 1'b0;
    step;
    q = {8'h00};
    applyStimulus(32, q, 16'hF660, crc, match);
    checkOutput("rstmid_fresh_crc", crc, 16'hF660);

    crc_ready = 1'b0;
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(8'($urandom));
    applyStimulus(32, q, 16'h0000, crc, match);
    rst = 1'b1;
    step;
    checkOutput("rstdone_valid", 16'(cv32), 16'd0);
    checkOutput("rstdone_crc", c32, 16'h0000);
    rst = 1'b0;
    crc_ready = 1'b1;
    step;
    q = {8'h00};
    applyStimulus(32, q, 16'hF660, crc, match);
    checkOutput("rstdone_fresh_crc", crc, 16'hF660);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcie_dllp_crc_engine.md
Name: pcie_dllp_crc_engine

Overview:
- Sequential, parametrised DLLP CRC-16 engine for the data link layer.
- Polynomial 0x100B, processed LSB-first, so the register shifts right with constant 0xD008.
- Accepts DATA_W bits per beat with byte enables and a valid/ready handshake, and accumulates the CRC across multi-beat frames.
- Presents the final CRC, plus an optional compare against a received CRC, on a held result interface.
- Used by both the DLLP transmit path (generate) and the receive path (check).

Parameters:
- DATA_W, 32, beat width in bits; legal values 8, 16, 32, 64.
- POLY_REFL, 16'hD008, reflected polynomial XORed on each LSB=1 shift.
- CRC_INIT, 16'hFFFF, accumulator value at start of every frame.
- OUT_INVERT, 1, 1 = crc_o is the bitwise complement of the accumulator; 0 = raw accumulator.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  engine can accept a beat.
- s_data_i  in  DATA_W  beat data; lane 0 = [7:0], processed first.
- s_keep_i  in  DATA_W/8  byte enables; only honoured on the last beat.
- s_last_i  in  1  final beat of frame.
- s_clear_i  in  1  abort current frame; accumulator returns to CRC_INIT.
- crc_rx_i  in  16  received CRC, sampled on the last-beat handshake.
- crc_valid_o  out  1  result valid.
- crc_ready_i  in  1  result consumer ready.
- crc_o  out  16  final CRC.
- crc_match_o  out  1  crc_o == sampled crc_rx_i.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state = ACCUM, accumulator = CRC_INIT, crc_valid_o = 0, crc_o = 0, crc_match_o = 0. s_ready_o = 0 during any cycle rst_i is high.
- Byte step:
  - c = c ^ {8'h00, byte}.
  - Then 8 iterations: c = c[0] ? (c>>1)^POLY_REFL : c>>1.
- Beat step: byte steps are applied to lanes 0..DATA_W/8-1 in order, combinationally within one cycle.
- Lane masking on the last beat:
  - Only lanes with s_keep_i=1 are processed.
  - s_keep_i must be contiguous from lane 0. Non-contiguous keep is undefined and flagged by a simulation assertion.
  - On non-last beats s_keep_i is ignored and treated as all-ones.
- States: ACCUM, DONE.
- ACCUM:
  - s_ready_o = 1.
  - Handshake = s_valid_i & s_ready_o.
  - Non-last handshake: accumulator <= beat step.
  - Last handshake:
    - Compute the final value f. crc_o <= OUT_INVERT ? ~f : f.
    - crc_match_o <= (that value == crc_rx_i).
    - crc_valid_o <= 1; accumulator <= CRC_INIT; go to DONE.
- DONE:
  - s_ready_o = 0; crc_o and crc_match_o are held stable.
  - When crc_ready_i = 1: crc_valid_o <= 0 and go to ACCUM next cycle. There is no same-cycle bypass.
- Latency: crc_valid_o rises the cycle after the last-beat handshake.
- Throughput: N-beat frame with crc_ready_i held high takes N+1 cycles.
- s_clear_i:
  - In ACCUM, takes priority over the beat: accumulator <= CRC_INIT. A beat presented in the same cycle is accepted (s_ready_o = 1) and discarded, including a last beat, so no result is produced.
  - In DONE, s_clear_i is ignored; the result is still delivered.
- Last beat with s_keep_i = 0: zero bytes processed, so the result is the transform of the accumulator as it stands.
- Reset mid-frame or in DONE: return immediately to the reset state; the pending result is lost.
- Equivalence requirement: for any byte stream, the result is independent of DATA_W and of beat partitioning.

Test Plan:
- DATA_W=8, single last beat 0x00, keep=1 -> crc_valid_o one cycle later, crc_o = 16'hF660 (raw accumulator 16'h099F). With crc_rx_i=16'hF660, crc_match_o = 1.
- DATA_W=32, last beat with s_keep_i=4'b0000 -> crc_o = 16'h0000 (~16'hFFFF). With crc_rx_i=16'h0001, crc_match_o = 0.
- Random 4-byte DLLP payloads: DATA_W=8 (4 beats), DATA_W=16 (2 beats) and DATA_W=32 (1 beat) must all produce crc_o equal to the byte-serial model. Also a 6-byte frame at DATA_W=32 with keep=4'b0011 on the second beat must match the model.
- Backpressure: hold crc_ready_i=0 for 5 cycles after the result -> crc_valid_o stays 1, crc_o stable, s_ready_o=0, and offered beats are not consumed. Releasing crc_ready_i gives s_ready_o=1 on the following cycle.
- s_clear_i asserted with a mid-frame beat, then a fresh single-byte 0x00 frame -> crc_o = 16'hF660, and no result is produced for the aborted frame.
- rst_i asserted for one cycle mid-frame and during DONE -> crc_valid_o=0 next cycle. A subsequent 0x00 frame gives crc_o = 16'hF660.
